// File: rtl/hash_digest_reader.sv
// rtl/hash_digest_reader.sv - snapshots the final SHA-256 state and streams it as eight 32-bit words
module hash_digest_reader #(
    parameter int FINAL_BLOCK = 2,
    parameter int ZERO_BITS   = 32,
    parameter int BYTE_SWAP   = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   Block,
    input  logic         hash_done,
    input  logic [255:0] H_in,
    output logic [31:0]  word_out,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [2:0]   word_idx,
    output logic         word_last,
    output logic         hit,
    output logic         busy,
    output logic         digest_done,
    output logic         overrun
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state, state_nxt;
    logic [255:0]  snapshot;
    logic [2:0]    idx;
    logic          hit_q, overrun_q, done_q;
    logic [31:0]   words [8];
    logic [31:0]   cur_word;

    logic final_pulse, accept, last_hs, capture, drop;

    assign final_pulse = hash_done && (Block == 2'(FINAL_BLOCK));
    assign accept      = (state == SEND) && word_ready;
    assign last_hs     = accept && (idx == 3'd7);
    // A final pulse is only taken when the output path is free at the next edge.
    assign capture     = final_pulse && ((state == IDLE) || last_hs);
    assign drop        = final_pulse && (state == SEND) && !last_hs;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = SEND;
            SEND: if (last_hs && !capture) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot  <= '0;
            idx       <= '0;
            hit_q     <= 1'b0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_hs;
            if (capture) begin
                snapshot <= H_in;
                hit_q    <= (H_in[255 -: ZERO_BITS] == '0);
                idx      <= '0;
            end else if (accept) begin
                idx <= idx + 3'd1;
            end
            if (drop) overrun_q <= 1'b1;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_words
        assign words[g] = snapshot[255 - 32*g -: 32];
    end

    always_comb begin
        cur_word = words[idx];
        if (BYTE_SWAP != 0)
            cur_word = {cur_word[7:0], cur_word[15:8], cur_word[23:16], cur_word[31:24]};
    end

    always_comb begin
        word_valid  = (state == SEND);
        busy        = (state == SEND);
        word_out    = (state == SEND) ? cur_word : 32'd0;
        word_last   = (state == SEND) && (idx == 3'd7);
        word_idx    = idx;
        hit         = hit_q;
        overrun     = overrun_q;
        digest_done = done_q;
    end

endmodule

// File: tb/tb_hash_digest_reader.sv
// tb/tb_hash_digest_reader.sv - directed self-checking bench for hash_digest_reader
module tb_hash_digest_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   Block;
    logic         hash_done;
    logic [255:0] H_in;
    logic         word_ready;

    logic [31:0] wo [4];
    logic        wv [4], wl [4], ht [4], bz [4], dd [4], ov [4];
    logic [2:0]  wi [4];

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] HV  = 256'h00000000_0000ffff_12345678_9abcdef0_0f0f0f0f_f0f0f0f0_a5a5a5a5_5a5a5a5a;

    always #5 clk = ~clk;

    hash_digest_reader #(.FINAL_BLOCK(2), .ZERO_BITS(32), .BYTE_SWAP(0)) u0 (
        .clk(clk), .rst(rst), .Block(Block), .hash_done(hash_done), .H_in(H_in),
        .word_out(wo[0]), .word_valid(wv[0]), .word_ready(word_ready), .word_idx(wi[0]),
        .word_last(wl[0]), .hit(ht[0]), .busy(bz[0]), .digest_done(dd[0]), .overrun(ov[0]));
    hash_digest_reader #(.FINAL_BLOCK(2), .ZERO_BITS(32), .BYTE_SWAP(1)) u1 (
        .clk(clk), .rst(rst), .Block(Block), .hash_done(hash_done), .H_in(H_in),
        .word_out(wo[1]), .word_valid(wv[1]), .word_ready(word_ready), .word_idx(wi[1]),
        .word_last(wl[1]), .hit(ht[1]), .busy(bz[1]), .digest_done(dd[1]), .overrun(ov[1]));
    hash_digest_reader #(.FINAL_BLOCK(2), .ZERO_BITS(48), .BYTE_SWAP(0)) u2 (
        .clk(clk), .rst(rst), .Block(Block), .hash_done(hash_done), .H_in(H_in),
        .word_out(wo[2]), .word_valid(wv[2]), .word_ready(word_ready), .word_idx(wi[2]),
        .word_last(wl[2]), .hit(ht[2]), .busy(bz[2]), .digest_done(dd[2]), .overrun(ov[2]));
    hash_digest_reader #(.FINAL_BLOCK(2), .ZERO_BITS(49), .BYTE_SWAP(0)) u3 (
        .clk(clk), .rst(rst), .Block(Block), .hash_done(hash_done), .H_in(H_in),
        .word_out(wo[3]), .word_valid(wv[3]), .word_ready(word_ready), .word_idx(wi[3]),
        .word_last(wl[3]), .hit(ht[3]), .busy(bz[3]), .digest_done(dd[3]), .overrun(ov[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wsel(input logic [255:0] h, input int k);
        return h[255 - 32*k -: 32];
    endfunction

    task automatic check_word(input logic [255:0] h, input int k);
        chk("word_out", wo[0], wsel(h, k));
        chk("word_idx", 32'(wi[0]), 32'(k));
        chkb("word_valid", wv[0], 1'b1);
        chkb("word_last", wl[0], k == 7);
        chkb("busy", bz[0], 1'b1);
    endtask

    task automatic capture(input logic [255:0] h);
        Block     = 2'd2;
        hash_done = 1'b1;
        H_in      = h;
        step();
        hash_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Block = 2'd0; hash_done = 1'b0; H_in = '0; word_ready = 1'b1;
        step();
        step();
        chk("rst_word_out", wo[0], 32'd0);
        chkb("rst_valid", wv[0], 1'b0);
        chk("rst_idx", 32'(wi[0]), 32'd0);
        chkb("rst_hit", ht[0], 1'b0);
        chkb("rst_busy", bz[0], 1'b0);
        chkb("rst_overrun", ov[0], 1'b0);
        rst = 1'b0;
        step();

        // Non-final block pulse is ignored
        Block = 2'd1; hash_done = 1'b1; H_in = ABC;
        step();
        hash_done = 1'b0;
        chkb("blk1_busy", bz[0], 1'b0);
        chkb("blk1_valid", wv[0], 1'b0);
        chkb("blk1_overrun", ov[0], 1'b0);

        // abc digest, ready high, back-to-back capture on the H7 handshake
        capture(ABC);
        chkb("abc_hit", ht[0], 1'b0);
        for (int k = 0; k < 8; k++) begin
            check_word(ABC, k);
            if (k == 0) chk("swap_first", wo[1], 32'hbf1678ba);
            if (k == 7) begin
                chk("swap_last", wo[1], 32'had1500f2);
                Block = 2'd2; hash_done = 1'b1; H_in = HV;
            end
            step();
        end
        hash_done = 1'b0;
        chkb("b2b_done", dd[0], 1'b1);
        chkb("b2b_busy", bz[0], 1'b1);
        chkb("b2b_overrun", ov[0], 1'b0);
        chkb("hit_zb32", ht[0], 1'b1);
        chkb("hit_zb48", ht[2], 1'b1);
        chkb("hit_zb49", ht[3], 1'b0);
        for (int k = 0; k < 8; k++) begin
            check_word(HV, k);
            step();
        end
        chkb("hv_done", dd[0], 1'b1);
        chkb("hv_busy", bz[0], 1'b0);
        chkb("hv_valid", wv[0], 1'b0);
        chk("hv_idle_word", wo[0], 32'd0);
        step();
        chkb("hv_done_pulse", dd[0], 1'b0);
        chkb("hv_hit_held", ht[0], 1'b1);

        // Backpressure at word 2, dropped final pulse at word 4
        capture(ABC);
        for (int k = 0; k < 8; k++) begin
            check_word(ABC, k);
            if (k == 2) begin
                word_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk("stall_word", wo[0], 32'h414140de);
                    chk("stall_idx", 32'(wi[0]), 32'd2);
                    chkb("stall_done", dd[0], 1'b0);
                end
                word_ready = 1'b1;
            end
            if (k == 4) begin
                Block = 2'd2; hash_done = 1'b1; H_in = HV;
            end
            step();
            hash_done = 1'b0;
            if (k == 4) begin
                chkb("drop_overrun", ov[0], 1'b1);
                chkb("drop_hit", ht[0], 1'b0);
            end
        end
        chkb("bp_done", dd[0], 1'b1);
        chkb("bp_busy", bz[0], 1'b0);
        step();

        // Reset mid-stream at word 5
        capture(ABC);
        for (int k = 0; k < 5; k++) step();
        chk("pre_rst_idx", 32'(wi[0]), 32'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chkb("mrst_valid", wv[0], 1'b0);
        chkb("mrst_busy", bz[0], 1'b0);
        chk("mrst_idx", 32'(wi[0]), 32'd0);
        chkb("mrst_hit", ht[0], 1'b0);
        chkb("mrst_overrun", ov[0], 1'b0);
        chkb("mrst_done", dd[0], 1'b0);
        step();
        chkb("mrst_done2", dd[0], 1'b0);
        capture(ABC);
        for (int k = 0; k < 8; k++) begin
            check_word(ABC, k);
            step();
        end
        chkb("post_rst_done", dd[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
